// File: rtl/ram_port_arbiter.sv
// Two-master arbiter/sequencer for a single-port 8192x32 byte-enabled RAM; accept in IDLE, issue next cycle, read data one cycle later.
// Optional round-robin grant when RAM_ARB_ROUND_ROBIN_EN is defined, otherwise m0 has fixed priority.
module ram_port_arbiter #(
    parameter int ADDR_W = 13,
    parameter int DATA_W = 32
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [ADDR_W-1:0]   m0_address,
    input  logic [DATA_W/8-1:0] m0_byteenable,
    input  logic                m0_read,
    input  logic                m0_write,
    input  logic [DATA_W-1:0]   m0_writedata,
    output logic                m0_waitrequest,
    output logic [DATA_W-1:0]   m0_readdata,
    output logic                m0_readdatavalid,
    input  logic [ADDR_W-1:0]   m1_address,
    input  logic [DATA_W/8-1:0] m1_byteenable,
    input  logic                m1_read,
    input  logic                m1_write,
    input  logic [DATA_W-1:0]   m1_writedata,
    output logic                m1_waitrequest,
    output logic [DATA_W-1:0]   m1_readdata,
    output logic                m1_readdatavalid,
    output logic [ADDR_W-1:0]   ram_address,
    output logic [DATA_W/8-1:0] ram_byteenable,
    output logic                ram_chipselect,
    output logic                ram_write,
    output logic [DATA_W-1:0]   ram_writedata,
    output logic                ram_clken,
    input  logic [DATA_W-1:0]   ram_readdata
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_RESP  = 2'd2
    } state_t;

    state_t                r_state;
    state_t                w_next_state;
    logic                  r_owner;
    logic                  r_is_write;
    logic [ADDR_W-1:0]     r_ram_address;
    logic [DATA_W/8-1:0]   r_ram_byteenable;
    logic [DATA_W-1:0]     r_ram_writedata;
    logic                  r_ram_chipselect;
    logic                  r_ram_write;

    logic                  w_req0;
    logic                  w_req1;
    logic                  w_grant1;
    logic                  w_accept;
    logic                  w_sel_write;

    assign w_req0 = m0_read | m0_write;
    assign w_req1 = m1_read | m1_write;

`ifdef RAM_ARB_ROUND_ROBIN_EN
    logic r_last_m1;

    // On a tie, grant the master that did not win the previous accept.
    assign w_grant1 = w_req1 & (~w_req0 | ~r_last_m1);

    always_ff @(posedge clk) begin
        if (reset) begin
            r_last_m1 <= 1'b1;
        end else if (w_accept) begin
            r_last_m1 <= w_grant1;
        end
    end
`else
    assign w_grant1 = w_req1 & ~w_req0;
`endif

    // A write strobe takes precedence over a read strobe from the same master.
    assign w_sel_write = w_grant1 ? m1_write : m0_write;

    always_comb begin
        w_next_state = r_state;
        w_accept     = 1'b0;
        case (r_state)
            S_IDLE: begin
                if ((w_req0 | w_req1) && !reset) begin
                    w_accept     = 1'b1;
                    w_next_state = S_ISSUE;
                end
            end
            S_ISSUE: begin
                w_next_state = r_is_write ? S_IDLE : S_RESP;
            end
            S_RESP: begin
                w_next_state = S_IDLE;
            end
            default: begin
                w_next_state = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state          <= S_IDLE;
            r_owner          <= 1'b0;
            r_is_write       <= 1'b0;
            r_ram_address    <= '0;
            r_ram_byteenable <= '0;
            r_ram_writedata  <= '0;
            r_ram_chipselect <= 1'b0;
            r_ram_write      <= 1'b0;
        end else begin
            r_state <= w_next_state;
            if (w_accept) begin
                r_owner          <= w_grant1;
                r_is_write       <= w_sel_write;
                r_ram_address    <= w_grant1 ? m1_address    : m0_address;
                r_ram_byteenable <= w_grant1 ? m1_byteenable : m0_byteenable;
                r_ram_writedata  <= w_grant1 ? m1_writedata  : m0_writedata;
                r_ram_chipselect <= 1'b1;
                r_ram_write      <= w_sel_write;
            end else if (r_state == S_ISSUE) begin
                r_ram_chipselect <= 1'b0;
                r_ram_write      <= 1'b0;
            end
        end
    end

    assign m0_waitrequest   = ~(w_accept & ~w_grant1);
    assign m1_waitrequest   = ~(w_accept & w_grant1);
    assign m0_readdatavalid = (r_state == S_RESP) & ~r_owner;
    assign m1_readdatavalid = (r_state == S_RESP) & r_owner;
    assign m0_readdata      = ram_readdata;
    assign m1_readdata      = ram_readdata;

    assign ram_address    = r_ram_address;
    assign ram_byteenable = r_ram_byteenable;
    assign ram_writedata  = r_ram_writedata;
    assign ram_chipselect = r_ram_chipselect;
    assign ram_write      = r_ram_write;
    assign ram_clken      = 1'b1;

endmodule

// File: doc/ram_port_arbiter.md
# ram_port_arbiter

Two-requester arbiter and sequencer for the 8192 x 32 single-port on-chip RAM with byte enables. It sits between two Avalon-MM-style masters (m0, m1) and the RAM slave port, serialising their reads and writes onto one RAM port. It owns RAM chipselect/write/clock-enable sequencing and routes the one-cycle-latency read data back to the winning master with readdatavalid.

## Interface
- ADDR_W, 13, word address width (8192 words)
- DATA_W, 32, data width; byteenable width is DATA_W/8
- clk  in  1  system clock
- reset  in  1  synchronous, active-high reset
- mN_address  in  ADDR_W  word address (N = 0, 1)
- mN_byteenable  in  4  write byte lanes
- mN_read / mN_write  in  1  request strobes, held until accepted
- mN_writedata  in  DATA_W  write data
- mN_waitrequest  out  1  high = request not accepted this cycle
- mN_readdata  out  DATA_W  read data, valid when mN_readdatavalid
- mN_readdatavalid  out  1  one-cycle read response strobe
- ram_address  out  ADDR_W  RAM address
- ram_byteenable  out  4  RAM byte enables
- ram_chipselect / ram_write  out  1  RAM strobes
- ram_writedata  out  DATA_W  RAM write data
- ram_clken  out  1  RAM clock enable, tied 1 after reset
- ram_readdata  in  DATA_W  RAM q (unregistered output, 1-cycle latency from address)

## Operation
- FSM states: IDLE, ISSUE, RESP. Reset -> IDLE.
- IDLE: if any mN_read|mN_write, pick winner, deassert winner's waitrequest for that cycle (accept), register command into ram_* regs, store owner, go ISSUE. Loser keeps waitrequest=1.
- Both strobes from one master: write wins; read is ignored (master must re-request).
- ISSUE: ram_chipselect=1, ram_write=1 for writes. Write -> IDLE. Read -> RESP.
- RESP: owner's readdatavalid=1, mN_readdata = ram_readdata. -> IDLE.
- Only one transaction in flight; no acceptance outside IDLE.
- waitrequest is 1 in all cycles except the accept cycle.
- byteenable 4'b0000 on write: passed to RAM, no bytes change, response timing unchanged.
- mN_readdata outputs driven with ram_readdata at all times; only readdatavalid qualifies.

## Timing
- Reset values: all mN_waitrequest=1, mN_readdatavalid=0, ram_chipselect=0, ram_write=0, ram_address=0, ram_byteenable=0, ram_writedata=0, ram_clken=1, FSM=IDLE, round-robin pointer = "m1 last" (m0 wins first contest).
- Accept at cycle T (waitrequest=0, strobe sampled). ISSUE at T+1 (RAM strobes high). Write commits at end of T+1.
- Read: readdatavalid at T+2 (exactly one cycle). FSM back to IDLE at T+3.
- Throughput: one write per 2 cycles, one read per 3 cycles.
- Reset asserted in ISSUE or RESP: next cycle all outputs at reset values; pending readdatavalid suppressed; a write already in ISSUE on the reset edge is not guaranteed.
- Request withdrawn before acceptance: legal, nothing issued.

## Configuration
- RAM_ARB_ROUND_ROBIN_EN defined: on simultaneous requests in IDLE, grant goes to the master not granted last; pointer updates on every accept.
- Not defined: fixed priority, m0 always wins simultaneous requests; m1 granted only when m0 idle; pointer logic absent.

## Test plan
- Single read: m0_read addr 0x0010 after write 0xDEADBEEF there -> waitrequest low at T, m0_readdatavalid at T+2 with 0xDEADBEEF, m1 outputs quiet.
- Byte write: m1_write addr 0x1FFF be 4'b0100 data 0x00AB0000 over 0x11223344 -> read back 0x11AB3344.
- Contention with RAM_ARB_ROUND_ROBIN_EN: both masters read continuously -> grants alternate m0,m1,m0,m1 every 3 cycles; without macro -> m0 every grant, m1 never until m0 drops.
- Read+write same master same cycle: m0_read=m0_write=1 addr 0x0005 data 0x5 -> write performed, no readdatavalid.
- Reset in RESP: reset during read's RESP-1 cycle -> no readdatavalid, all outputs at reset values next cycle, next request accepted from IDLE normally.
- Back-to-back writes m0 and reads m1 at addr 0x0000: m1 sees value from the write accepted before it, never a stale one.
